// File: rtl/mips_mem_pkg.sv
// Shared types and lane-mapping helpers for the MIPS memory bus bridge.
// Lanes are big-endian: byte offset 0 is the most significant byte lane.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        RDWAIT = 2'b10,
        DONE   = 2'b11
    } bridge_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_BYTE0   = 4'b1000;

    // Raw size code 2'b11 behaves like a word access.
    function automatic mem_size_t decode_size(input logic [1:0] code);
        case (code)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    // Halves need an even offset, words need offset zero.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

    // Byte offset k owns enable bit 3-k.
    function automatic logic [3:0] lane_enables(input mem_size_t size, input logic [1:0] offset);
        case (size)
            BYTE:    return BE_BYTE0 >> offset;
            HALF:    return offset[1] ? BE_HALF_LO : BE_HALF_HI;
            default: return BE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane steering: byte enables, replicated store data and
// right-justified, extended load data.
module byte_lane_unit
    import mips_mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byteenable,
    output logic [31:0] write_data,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Enables and replicated store data so any enabled lane carries the value.
    always_comb begin
        byteenable = lane_enables(size, offset);
        case (size)
            BYTE:    write_data = {4{store_data[7:0]}};
            HALF:    write_data = {2{store_data[15:0]}};
            default: write_data = store_data;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = read_word[31:24];
            2'd1:    byte_sel = read_word[23:16];
            2'd2:    byte_sel = read_word[15:8];
            default: byte_sel = read_word[7:0];
        endcase
        half_sel = offset[1] ? read_word[15:0] : read_word[31:16];
        case (size)
            BYTE:    load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            HALF:    load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = read_word;
        endcase
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Runs one CPU load/store as a single Avalon-MM transaction and holds the
// core in stall until it completes. Lane steering lives in byte_lane_unit.
module mem_bus_bridge
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    output logic        stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    bridge_state_t state;
    bridge_state_t next_state;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    mem_size_t   size_q;
    logic        signed_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    byte_lane_unit u_lanes (
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .sign_ext   (signed_q),
        .store_data (wdata_q),
        .read_word  (avm_readdata),
        .byteenable (lane_be),
        .write_data (lane_wdata),
        .load_data  (lane_load)
    );

    // State register; reset abandons any bus request in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Latch the request in IDLE so the bus sees stable copies; capture read data in RDWAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= BYTE;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else if (state == IDLE && cpu_req) begin
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            size_q   <= decode_size(cpu_size);
            signed_q <= cpu_signed;
            write_q  <= cpu_write;
            err_q    <= is_misaligned(decode_size(cpu_size), cpu_addr[1:0]);
            rdata_q  <= '0;
        end else if (state == RDWAIT) begin
            rdata_q  <= lane_load;
        end
    end

    // Misaligned requests skip the bus; DONE always returns to IDLE so a held request is not re-taken.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cpu_req)
                    next_state = is_misaligned(decode_size(cpu_size), cpu_addr[1:0]) ? DONE : REQ;
            end
            REQ: begin
                if (!avm_waitrequest)
                    next_state = write_q ? DONE : RDWAIT;
            end
            RDWAIT:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stall is combinational so the control FSM sees it in the request cycle itself.
    always_comb begin
        stall          = (state == IDLE && cpu_req) || state == REQ || state == RDWAIT;
        avm_read       = (state == REQ) && !write_q;
        avm_write      = (state == REQ) && write_q;
        avm_byteenable = (state == REQ) ? lane_be : 4'b0000;
        cpu_done       = (state == DONE);
        cpu_err        = (state == DONE) && err_q;
    end

    assign avm_address   = {addr_q[31:2], 2'b00};
    assign avm_writedata = lane_wdata;
    assign cpu_rdata     = rdata_q;

endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Memory-side responder for the multicycle MIPS core. It accepts a single load or store request from the datapath/control unit and runs it as one Avalon-MM transaction. It returns load data aligned and sign-extended, and drives the `stall` input that holds the control FSM in EXEC_1 until the access completes. All big-endian byte-lane steering for byte, halfword and word accesses happens here.

## Interface
Parameters:
- none; address and data are fixed at 32 bits.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: access request, level; held high until `stall` reads 0.
- `cpu_write` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-justified for byte/half.
- `cpu_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `cpu_signed` in 1: sign-extend byte/half loads.
- `stall` out 1: access in progress.
- `cpu_rdata` out 32: load result, valid when `cpu_done`=1.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_err` out 1: one-cycle misalignment pulse, coincident with `cpu_done`.
- `avm_address` out 32: word-aligned address (`cpu_addr[31:2]`,2'b00).
- `avm_read` out 1: Avalon read.
- `avm_write` out 1: Avalon write.
- `avm_writedata` out 32: Avalon write data.
- `avm_byteenable` out 4: Avalon byte enables.
- `avm_waitrequest` in 1: Avalon wait request.
- `avm_readdata` in 32: Avalon read data, fixed latency 1 cycle after acceptance.

## Operation
- FSM states: IDLE, REQ, RDWAIT, DONE.
- IDLE, `cpu_req`=1: latch addr/wdata/size/signed/write; misaligned → DONE with err; else → REQ.
- Misaligned: half with `addr[0]`=1, or word with `addr[1:0]`≠0. No bus cycle is issued. `cpu_rdata`=0.
- REQ: drive `avm_read` or `avm_write`.
  - `avm_waitrequest`=1: stay in REQ; address, data, enables and strobes stay stable.
  - `avm_waitrequest`=0: accepted. A store → DONE; a load → RDWAIT.
- RDWAIT: capture `avm_readdata` → DONE.
- DONE: `cpu_done`=1, `stall`=0 → IDLE unconditionally.
- `stall` = (IDLE and `cpu_req`) or REQ or RDWAIT. It is combinational so the control FSM sees it in the request cycle.
- Lane mapping is big-endian. Byte offset k selects bits [31-8k:24-8k] and `avm_byteenable` bit 3-k.
  - Half at offset 0 → enables 1100, bits [31:16].
  - Half at offset 2 → enables 0011, bits [15:0].
  - Word → enables 1111.
- Store data is replicated across lanes: byte {4{b}}, half {2{h}}, word as-is.
- Load result is right-justified, then zero- or sign-extended per `cpu_signed`; word loads pass through unchanged.

## Timing
- Reset values: state IDLE; `avm_read`, `avm_write`, `cpu_done`, `cpu_err` = 0; `avm_byteenable` 0000; `cpu_rdata` 0; address and data registers 0.
- Read with no wait states: `stall` high for cycles 0–2; DONE in cycle 3. Total latency 3 + N, where N is the number of wait-request cycles.
- Write with no wait states: DONE in cycle 2. Latency 2 + N.
- Misaligned access: DONE in cycle 1, no bus strobes.
- `cpu_req` still high in the DONE cycle is not a new request. A request seen in the following IDLE cycle starts a new access, so back-to-back accesses are allowed.
- `cpu_*` inputs are ignored outside IDLE; latched copies drive the bus.
- Reset mid-transaction: the next edge goes to IDLE and strobes drop. The bus slave must tolerate an abandoned request.
- `avm_read` and `avm_write` are never both 1.

## Structure
- Shared package `mips_mem_pkg`:
  - `mem_size_t` enum (BYTE, HALF, WORD).
  - `bridge_state_t` enum.
  - Lane-mapping constant helpers.
- Combinational sub-module `byte_lane_unit`:
  - Inputs: size, offset, signed flag, store data, read word.
  - Outputs: byteenable, replicated write data, extended load data.
- Top level holds the FSM and registers only.

## Test plan
- LB, addr 0x1003, readdata 0x1122_3380, signed → enables 0001, `cpu_rdata` 0xFFFF_FF80, `cpu_done` in cycle 3.
- LBU, addr 0x1000, readdata 0x8A00_0000 → enables 1000, `cpu_rdata` 0x0000_008A.
- SW, addr 0x2004, wdata 0xDEAD_BEEF, 2 wait states → `avm_address` 0x2004; write held 3 cycles with stable data; `cpu_done` in cycle 4; `stall` high in cycles 0–3.
- SB, addr 0x2002, wdata 0x0000_0055 → enables 0010, writedata 0x5555_5555.
- LW, addr 0x3002 → no `avm_read`; `cpu_err`=`cpu_done`=1 in cycle 1; `cpu_rdata` 0.
- `reset` asserted in REQ while `avm_waitrequest`=1 → next cycle IDLE with strobes 0. A following LW to 0x10 completes normally.
